// File: rtl/priority_span_calc.sv
// priority_span_calc: turns one-hot left/right encoder outputs into bit indices and an inclusive span,
//   then buffers results in a first-word-fall-through FIFO with valid/ready output.
// Latency: data_val_i sampled at edge E0 -> data_val_o high after edge E2 (empty FIFO).
// Backpressure: none upstream; when the FIFO is full and not popped, the result is dropped and overflow_o sticks.
//
// Ports:
//   clk_i, srst_i                   clock, synchronous active-high reset
//   data_left_i/right_i/val_i       one-hot encoder outputs plus valid (no ready)
//   left_idx_o, right_idx_o, span_o head entry: indices and span (left - right + 1)
//   zero_o, onehot_err_o            head entry flags
//   data_val_o, data_ready_i        output handshake; pop on data_val_o & data_ready_i
//   overflow_o                      sticky drop indicator, cleared only by srst_i
//   level_o                         FIFO occupancy, present only with PRIORITY_SPAN_CALC_LEVEL_EN
// Optional feature macro: PRIORITY_SPAN_CALC_LEVEL_EN
module priority_span_calc #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 8,
  localparam int IDX_W  = $clog2(WIDTH),
  localparam int SPAN_W = $clog2(WIDTH + 1),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [WIDTH-1:0]  data_left_i,
  input  logic [WIDTH-1:0]  data_right_i,
  input  logic              data_val_i,
  output logic [IDX_W-1:0]  left_idx_o,
  output logic [IDX_W-1:0]  right_idx_o,
  output logic [SPAN_W-1:0] span_o,
  output logic              zero_o,
  output logic              onehot_err_o,
  output logic              data_val_o,
  input  logic              data_ready_i,
  output logic              overflow_o
`ifdef PRIORITY_SPAN_CALC_LEVEL_EN
  ,
  output logic [CNT_W-1:0]  level_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]  left_idx;
    logic [IDX_W-1:0]  right_idx;
    logic [SPAN_W-1:0] span;
    logic              zero;
    logic              err;
  } res_t;

  // ---------------------------------------------------------------
  // Input capture: the encoder output is registered before the wide
  // priority logic so the 50-bit search starts from a flop.
  // ---------------------------------------------------------------
  logic             in_vld;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      in_vld   <= 1'b0;
      in_left  <= '0;
      in_right <= '0;
    end else begin
      in_vld <= data_val_i;
      if (data_val_i) begin
        in_left  <= data_left_i;
        in_right <= data_right_i;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 1 compute: highest set bit of left, lowest set bit of right,
  // so a multi-hot word still yields the outermost span.
  // ---------------------------------------------------------------
  logic [IDX_W-1:0] l_idx;
  logic [IDX_W-1:0] r_idx;
  logic             l_nz;
  logic             r_nz;
  logic             l_multi;
  logic             r_multi;
  logic             order_err;
  res_t             calc;

  always_comb begin
    l_idx = '0;
    r_idx = '0;
    // Ascending scan: last hit is the highest set bit.
    for (int i = 0; i < WIDTH; i++) begin
      if (in_left[i]) l_idx = IDX_W'(i);
    end
    // Descending scan: last hit is the lowest set bit.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_right[i]) r_idx = IDX_W'(i);
    end
  end

  assign l_nz      = |in_left;
  assign r_nz      = |in_right;
  // x & (x-1) clears the lowest set bit; anything left means more than one bit.
  assign l_multi   = |(in_left  & (in_left  - WIDTH'(1)));
  assign r_multi   = |(in_right & (in_right - WIDTH'(1)));
  assign order_err = (l_idx < r_idx);

  always_comb begin
    calc           = '0;
    calc.left_idx  = l_idx;
    calc.right_idx = r_idx;
    calc.zero      = ~l_nz & ~r_nz;
    calc.err       = l_multi | r_multi | (l_nz ^ r_nz) | order_err;
    if (!calc.zero && !order_err) begin
      calc.span = SPAN_W'(l_idx) - SPAN_W'(r_idx) + SPAN_W'(1);
    end
  end

  logic s1_vld;
  res_t s1_res;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      s1_vld <= 1'b0;
      s1_res <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) s1_res <= calc;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: FWFT FIFO. A push into a full FIFO is allowed when the
  // head leaves on the same edge.
  // ---------------------------------------------------------------
  res_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ovf;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = ~empty & data_ready_i;
  assign push  = s1_vld & (~full | pop);

  always_ff @(posedge clk_i) begin
    if (!srst_i && push) mem[wr_ptr] <= s1_res;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s1_vld && full && !pop) ovf <= 1'b1;
    end
  end

  // Outputs read zero while empty so stale memory never shows.
  res_t head;

  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign left_idx_o   = head.left_idx;
  assign right_idx_o  = head.right_idx;
  assign span_o       = head.span;
  assign zero_o       = head.zero;
  assign onehot_err_o = head.err;
  assign data_val_o   = ~empty;
  assign overflow_o   = ovf;

`ifdef PRIORITY_SPAN_CALC_LEVEL_EN
  assign level_o = count;
`endif

endmodule
